// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-stage access unit.
// Contents: operation and FSM state encodings, default stack bounds,
// and small helpers for decoding ops and classifying their behaviour.
package mem_access_unit_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LDM  = 3'd1,
        OP_LDD  = 3'd2,
        OP_STD  = 3'd3,
        OP_PUSH = 3'd4,
        OP_POP  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic [19:0] DEF_SP_INIT  = 20'hFFFFF;
    localparam logic [19:0] DEF_SP_LIMIT = 20'hFF000;

    // Reserved encodings 6 and 7 behave exactly like NOP.
    function automatic op_e decode_op(input logic [2:0] raw);
        case (raw)
            3'd1:    return OP_LDM;
            3'd2:    return OP_LDD;
            3'd3:    return OP_STD;
            3'd4:    return OP_PUSH;
            3'd5:    return OP_POP;
            default: return OP_NOP;
        endcase
    endfunction

    function automatic logic op_uses_mem(input op_e o);
        return (o == OP_LDD) || (o == OP_STD) || (o == OP_PUSH) || (o == OP_POP);
    endfunction

    function automatic logic op_writes(input op_e o);
        return (o == OP_STD) || (o == OP_PUSH);
    endfunction

    function automatic logic op_has_wb(input op_e o);
        return (o == OP_LDM) || (o == OP_LDD) || (o == OP_POP);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the access unit (master) and data memory (slave).
// Signals: mem_req/mem_we/mem_addr/mem_wdata from the unit,
// mem_rdata/mem_ready back from memory (rdata valid with ready).
interface mem_access_unit_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 20
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_access_unit_sp_unit.sv
// Stack-pointer register for the access unit.
// Ports: clk, rst_n (async active-low); commit_push/commit_pop apply the
// post-decrement / pre-increment; sp is the committed value; push_addr and
// pop_addr are the addresses those ops would touch; full flags that a push
// would overflow, empty that a pop would underflow.
module mem_access_unit_sp_unit #(
    parameter int                ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] SP_INIT  = '1,
    parameter logic [ADDR_W-1:0] SP_LIMIT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              commit_push,
    input  logic              commit_pop,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] push_addr,
    output logic [ADDR_W-1:0] pop_addr,
    output logic              full,
    output logic              empty
);
    logic [ADDR_W-1:0] sp_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_reg <= SP_INIT;
        end else if (commit_push) begin
            sp_reg <= sp_reg - ADDR_W'(1);
        end else if (commit_pop) begin
            sp_reg <= sp_reg + ADDR_W'(1);
        end
    end

    assign sp        = sp_reg;
    assign push_addr = sp_reg;
    assign pop_addr  = sp_reg + ADDR_W'(1);
    assign full      = (sp_reg < SP_LIMIT);
    assign empty     = (sp_reg == SP_INIT);
endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: decodes the memory op, forms address/write data,
// owns the stack pointer and runs the req/ready handshake to data memory.
// Ports: clk, rst_n (async active-low); in_valid/in_ready accept handshake
// with op, rs_val, rd_val, imm, rd_idx; mem (bus master); wb_valid/wb_idx/
// wb_data write-back pulse; done per accepted op; stack_err on stack
// overflow/underflow; sp_o committed stack pointer.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] SP_INIT  = ADDR_W'(DEF_SP_INIT),
    parameter logic [ADDR_W-1:0] SP_LIMIT = ADDR_W'(DEF_SP_LIMIT)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          op,
    input  logic [DATA_W-1:0]   rs_val,
    input  logic [DATA_W-1:0]   rd_val,
    input  logic [DATA_W-1:0]   imm,
    input  logic [2:0]          rd_idx,
    mem_access_unit_if.master   mem,
    output logic                wb_valid,
    output logic [2:0]          wb_idx,
    output logic [DATA_W-1:0]   wb_data,
    output logic                done,
    output logic                stack_err,
    output logic [ADDR_W-1:0]   sp_o
);
    state_e            state_reg, state_next;
    op_e               op_reg;
    logic [DATA_W-1:0] rs_reg, rd_reg, imm_reg, rdata_reg;
    logic [2:0]        idx_reg;
    logic              err_reg;

    logic              accept, in_access, in_resp, mem_done;
    logic              stack_fault, commit_push, commit_pop;
    logic              sp_full, sp_empty;
    logic [ADDR_W-1:0] push_addr, pop_addr, access_addr;
    logic [DATA_W-1:0] offset_sum;
    op_e               dec_op;

    assign dec_op      = decode_op(op);
    assign accept      = in_valid && (state_reg == ST_IDLE);
    // Stack bounds are judged against the SP as it stands at accept; a
    // faulting op skips memory entirely and reports in RESP.
    assign stack_fault = ((dec_op == OP_PUSH) && sp_full) ||
                         ((dec_op == OP_POP)  && sp_empty);

    assign in_access = (state_reg == ST_ACCESS);
    assign in_resp   = (state_reg == ST_RESP);
    assign mem_done  = in_access && mem.mem_ready;

    assign commit_push = mem_done && (op_reg == OP_PUSH);
    assign commit_pop  = mem_done && (op_reg == OP_POP);

    mem_access_unit_sp_unit #(
        .ADDR_W   (ADDR_W),
        .SP_INIT  (SP_INIT),
        .SP_LIMIT (SP_LIMIT)
    ) u_sp (
        .clk         (clk),
        .rst_n       (rst_n),
        .commit_push (commit_push),
        .commit_pop  (commit_pop),
        .sp          (sp_o),
        .push_addr   (push_addr),
        .pop_addr    (pop_addr),
        .full        (sp_full),
        .empty       (sp_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (op_uses_mem(dec_op) && !stack_fault) begin
                        state_next = ST_ACCESS;
                    end else begin
                        state_next = ST_RESP;
                    end
                end
            end
            ST_ACCESS: begin
                if (mem.mem_ready) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Operands are captured at accept so the pipeline inputs may change freely
    // while the access is in flight; the bus fields below stay stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg    <= OP_NOP;
            rs_reg    <= '0;
            rd_reg    <= '0;
            imm_reg   <= '0;
            idx_reg   <= '0;
            err_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            if (accept) begin
                op_reg  <= dec_op;
                rs_reg  <= rs_val;
                rd_reg  <= rd_val;
                imm_reg <= imm;
                idx_reg <= rd_idx;
                err_reg <= stack_fault;
            end
            if (mem_done && !op_writes(op_reg)) begin
                rdata_reg <= mem.mem_rdata;
            end
        end
    end

    // Offset addition wraps at DATA_W before zero-extension to the bus width.
    assign offset_sum = rs_reg + imm_reg;

    always_comb begin
        access_addr = ADDR_W'(offset_sum);
        if (op_reg == OP_PUSH) begin
            access_addr = push_addr;
        end else if (op_reg == OP_POP) begin
            access_addr = pop_addr;
        end
    end

    assign in_ready      = (state_reg == ST_IDLE);
    assign mem.mem_req   = in_access;
    assign mem.mem_we    = in_access && op_writes(op_reg);
    assign mem.mem_addr  = in_access ? access_addr : '0;
    assign mem.mem_wdata = mem.mem_we ? rd_reg : '0;

    assign done      = in_resp;
    assign stack_err = in_resp && err_reg;
    assign wb_valid  = in_resp && !err_reg && op_has_wb(op_reg);
    assign wb_idx    = wb_valid ? idx_reg : 3'd0;
    assign wb_data   = wb_valid ? ((op_reg == OP_LDM) ? imm_reg : rdata_reg) : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    localparam int          DATA_W   = 16;
    localparam int          ADDR_W   = 20;
    localparam logic [19:0] SP_INIT  = 20'hFFFFF;
    localparam logic [19:0] SP_LIMIT = 20'hFFFF8;   // small stack so overflow is reachable

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready;
    logic [2:0]  op, rd_idx, wb_idx;
    logic [15:0] rs_val, rd_val, imm, wb_data;
    logic        wb_valid, done, stack_err;
    logic [19:0] sp_o;

    always #5 clk = ~clk;

    mem_access_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_bus ();

    mem_access_unit #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SP_INIT(SP_INIT), .SP_LIMIT(SP_LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs_val(rs_val), .rd_val(rd_val), .imm(imm), .rd_idx(rd_idx),
        .mem(mem_bus.master),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
        .done(done), .stack_err(stack_err), .sp_o(sp_o)
    );

    int vectors = 0;
    int miscompares = 0;

    // Environment memory (what the bus really wrote) and reference memory
    // (what the model says should have been written).
    logic [15:0] env_mem [logic [19:0]];
    logic [15:0] ref_mem [logic [19:0]];
    logic [19:0] sp_model;

    // Observations of one transaction
    bit          obs_timeout, obs_unstable, obs_busy_ready, obs_ready_after;
    int          obs_req_cycles, obs_done_cycle;
    logic [19:0] obs_addr, obs_sp;
    logic        obs_we, obs_wb_valid, obs_err;
    logic [15:0] obs_wdata, obs_wb_data;
    logic [2:0]  obs_wb_idx;

    // Expectations of one transaction
    bit          exp_access, exp_we, exp_wb_valid, exp_err;
    int          exp_req_cycles, exp_done_cycle;
    logic [19:0] exp_addr, exp_sp;
    logic [15:0] exp_wdata, exp_wb_data;
    logic [2:0]  exp_wb_idx;

    function automatic logic [15:0] fill(input logic [19:0] a);
        return a[15:0] ^ 16'hC3A5;
    endfunction

    function automatic logic [15:0] ref_read(input logic [19:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : fill(a);
    endfunction

    // Reference model: what an op should do, from the op's definition alone.
    task automatic model(input logic [2:0] o, input logic [15:0] rs, input logic [15:0] rd,
                         input logic [15:0] im, input logic [2:0] idx, input int lat);
        logic [15:0] sum;
        exp_access = 0; exp_we = 0; exp_wb_valid = 0; exp_err = 0;
        exp_addr = '0; exp_wdata = '0; exp_wb_data = '0; exp_wb_idx = '0;
        sum = rs + im;
        case (o)
            3'd1: begin exp_wb_valid = 1; exp_wb_data = im; exp_wb_idx = idx; end
            3'd2: begin
                exp_access = 1; exp_addr = {4'h0, sum};
                exp_wb_valid = 1; exp_wb_idx = idx; exp_wb_data = ref_read(exp_addr);
            end
            3'd3: begin
                exp_access = 1; exp_addr = {4'h0, sum}; exp_we = 1; exp_wdata = rd;
                ref_mem[exp_addr] = rd;
            end
            3'd4: begin
                if (sp_model < SP_LIMIT) exp_err = 1;
                else begin
                    exp_access = 1; exp_addr = sp_model; exp_we = 1; exp_wdata = rd;
                    ref_mem[exp_addr] = rd;
                    sp_model = sp_model - 20'd1;
                end
            end
            3'd5: begin
                if (sp_model == SP_INIT) exp_err = 1;
                else begin
                    exp_access = 1; exp_addr = sp_model + 20'd1;
                    exp_wb_valid = 1; exp_wb_idx = idx; exp_wb_data = ref_read(exp_addr);
                    sp_model = sp_model + 20'd1;
                end
            end
            default: ;
        endcase
        exp_req_cycles = exp_access ? lat + 1 : 0;
        exp_done_cycle = exp_access ? lat + 2 : 1;
        exp_sp = sp_model;
    endtask

    // Drive one op at a negedge (unit idle), act as memory with `lat` wait
    // cycles, and record what the DUT did. Returns at the negedge after done.
    task automatic issue(input logic [2:0] o, input logic [15:0] rs, input logic [15:0] rd,
                         input logic [15:0] im, input logic [2:0] idx, input int lat);
        int cyc;
        bit finished;
        obs_timeout = 0; obs_unstable = 0; obs_req_cycles = 0; obs_done_cycle = -1;
        obs_addr = '0; obs_we = 0; obs_wdata = '0; obs_wb_valid = 0; obs_wb_idx = '0;
        obs_wb_data = '0; obs_err = 0; obs_sp = '0; obs_ready_after = 0;
        in_valid = 1; op = o; rs_val = rs; rd_val = rd; imm = im; rd_idx = idx;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0; op = 3'($urandom); rs_val = 16'($urandom); rd_val = 16'($urandom);
        imm = 16'($urandom); rd_idx = 3'($urandom);
        obs_busy_ready = in_ready;
        cyc = 1; finished = 0;
        while (!finished && cyc < 40) begin
            if (mem_bus.mem_req) begin
                if (obs_req_cycles == 0) begin
                    obs_addr = mem_bus.mem_addr; obs_we = mem_bus.mem_we; obs_wdata = mem_bus.mem_wdata;
                end else if (mem_bus.mem_addr !== obs_addr || mem_bus.mem_we !== obs_we ||
                             mem_bus.mem_wdata !== obs_wdata) begin
                    obs_unstable = 1;
                end
                obs_req_cycles++;
                if (obs_req_cycles == lat + 1) begin
                    mem_bus.mem_ready = 1;
                    if (mem_bus.mem_we) env_mem[mem_bus.mem_addr] = mem_bus.mem_wdata;
                    else mem_bus.mem_rdata = env_mem.exists(mem_bus.mem_addr) ?
                                             env_mem[mem_bus.mem_addr] : fill(mem_bus.mem_addr);
                end
            end
            if (done) begin
                obs_done_cycle = cyc; obs_wb_valid = wb_valid; obs_wb_idx = wb_idx;
                obs_wb_data = wb_data; obs_err = stack_err; obs_sp = sp_o;
                finished = 1;
            end
            @(negedge clk);
            mem_bus.mem_ready = 0;
            mem_bus.mem_rdata = 16'($urandom);
            if (finished) obs_ready_after = in_ready;
            else cyc++;
        end
        obs_timeout = !finished;
        $display("op=%0d rs=%h rd=%h imm=%h idx=%0d lat=%0d -> req=%0d addr=%h we=%0d done@%0d wb=%0d/%0d/%h err=%0d sp=%h",
                 o, rs, rd, im, idx, lat, obs_req_cycles, obs_addr, obs_we, obs_done_cycle,
                 obs_wb_valid, obs_wb_idx, obs_wb_data, obs_err, obs_sp);
    endtask

    task automatic apply_reset();
        rst_n = 0; in_valid = 0; mem_bus.mem_ready = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        sp_model = SP_INIT;
        @(negedge clk);
    endtask

    task automatic test_reset();
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        vectors++; if (mem_bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req got=%b exp=0", mem_bus.mem_req); end
        vectors++; if (done !== 1'b0 || wb_valid !== 1'b0 || stack_err !== 1'b0) begin
            miscompares++; $display("FAIL reset_pulses got=%b%b%b exp=000", done, wb_valid, stack_err); end
        vectors++; if (sp_o !== SP_INIT) begin miscompares++; $display("FAIL reset_sp got=%h exp=%h", sp_o, SP_INIT); end
    endtask

    task automatic test_ldm();
        model(3'd1, 16'h0, 16'h0, 16'h1234, 3'd3, 0);
        issue(3'd1, 16'h0, 16'h0, 16'h1234, 3'd3, 0);
        vectors++; if (obs_busy_ready !== 1'b0) begin miscompares++; $display("FAIL ldm_busy got=%b exp=0", obs_busy_ready); end
        vectors++; if (obs_done_cycle !== 1) begin miscompares++; $display("FAIL ldm_latency got=%0d exp=1", obs_done_cycle); end
        vectors++; if (obs_wb_valid !== 1'b1 || obs_wb_idx !== 3'd3) begin
            miscompares++; $display("FAIL ldm_wb got=%b/%0d exp=1/3", obs_wb_valid, obs_wb_idx); end
        vectors++; if (obs_wb_data !== 16'h1234) begin miscompares++; $display("FAIL ldm_data got=%h exp=1234", obs_wb_data); end
        vectors++; if (obs_req_cycles !== 0) begin miscompares++; $display("FAIL ldm_no_req got=%0d exp=0", obs_req_cycles); end
        vectors++; if (obs_ready_after !== 1'b1) begin miscompares++; $display("FAIL ldm_ready_after got=%b exp=1", obs_ready_after); end
    endtask

    task automatic test_std_wait();
        model(3'd3, 16'h0010, 16'hBEEF, 16'h0005, 3'd1, 3);
        issue(3'd3, 16'h0010, 16'hBEEF, 16'h0005, 3'd1, 3);
        vectors++; if (obs_addr !== 20'h00015 || obs_we !== 1'b1 || obs_wdata !== 16'hBEEF) begin
            miscompares++; $display("FAIL std_bus got=%h/%b/%h exp=00015/1/beef", obs_addr, obs_we, obs_wdata); end
        vectors++; if (obs_unstable !== 1'b0) begin miscompares++; $display("FAIL std_hold got=%b exp=0", obs_unstable); end
        vectors++; if (obs_req_cycles !== 4) begin miscompares++; $display("FAIL std_req_cycles got=%0d exp=4", obs_req_cycles); end
        vectors++; if (obs_done_cycle !== 5) begin miscompares++; $display("FAIL std_latency got=%0d exp=5", obs_done_cycle); end
        vectors++; if (obs_wb_valid !== 1'b0) begin miscompares++; $display("FAIL std_wb got=%b exp=0", obs_wb_valid); end
    endtask

    task automatic test_push_pop();
        model(3'd4, 16'h0, 16'hAAAA, 16'h0, 3'd0, 0);
        issue(3'd4, 16'h0, 16'hAAAA, 16'h0, 3'd0, 0);
        vectors++; if (obs_addr !== 20'hFFFFF || obs_we !== 1'b1 || obs_wdata !== 16'hAAAA) begin
            miscompares++; $display("FAIL push_bus got=%h/%b/%h exp=fffff/1/aaaa", obs_addr, obs_we, obs_wdata); end
        vectors++; if (obs_sp !== 20'hFFFFE) begin miscompares++; $display("FAIL push_sp got=%h exp=ffffe", obs_sp); end
        vectors++; if (obs_done_cycle !== 2) begin miscompares++; $display("FAIL push_latency got=%0d exp=2", obs_done_cycle); end
        model(3'd5, 16'h0, 16'h0, 16'h0, 3'd5, 0);
        issue(3'd5, 16'h0, 16'h0, 16'h0, 3'd5, 0);
        vectors++; if (obs_addr !== 20'hFFFFF || obs_we !== 1'b0) begin
            miscompares++; $display("FAIL pop_bus got=%h/%b exp=fffff/0", obs_addr, obs_we); end
        vectors++; if (obs_sp !== 20'hFFFFF) begin miscompares++; $display("FAIL pop_sp got=%h exp=fffff", obs_sp); end
        vectors++; if (obs_wb_valid !== 1'b1 || obs_wb_idx !== 3'd5 || obs_wb_data !== 16'hAAAA) begin
            miscompares++; $display("FAIL pop_wb got=%b/%0d/%h exp=1/5/aaaa", obs_wb_valid, obs_wb_idx, obs_wb_data); end
    endtask

    task automatic test_pop_underflow();
        model(3'd5, 16'h0, 16'h0, 16'h0, 3'd2, 0);
        issue(3'd5, 16'h0, 16'h0, 16'h0, 3'd2, 0);
        vectors++; if (obs_req_cycles !== 0) begin miscompares++; $display("FAIL uflow_no_req got=%0d exp=0", obs_req_cycles); end
        vectors++; if (obs_done_cycle !== 1 || obs_err !== 1'b1) begin
            miscompares++; $display("FAIL uflow_err got=%0d/%b exp=1/1", obs_done_cycle, obs_err); end
        vectors++; if (obs_wb_valid !== 1'b0 || obs_sp !== SP_INIT) begin
            miscompares++; $display("FAIL uflow_state got=%b/%h exp=0/%h", obs_wb_valid, obs_sp, SP_INIT); end
    endtask

    task automatic test_ldd_wrap();
        model(3'd2, 16'hFFFF, 16'h0, 16'h0002, 3'd6, 1);
        issue(3'd2, 16'hFFFF, 16'h0, 16'h0002, 3'd6, 1);
        vectors++; if (obs_addr !== 20'h00001 || obs_we !== 1'b0) begin
            miscompares++; $display("FAIL ldd_addr got=%h/%b exp=00001/0", obs_addr, obs_we); end
        vectors++; if (obs_wb_valid !== 1'b1 || obs_wb_data !== exp_wb_data || obs_wb_idx !== 3'd6) begin
            miscompares++; $display("FAIL ldd_wb got=%b/%h/%0d exp=1/%h/6", obs_wb_valid, obs_wb_data, obs_wb_idx, exp_wb_data); end
    endtask

    // Fill the stack to overflow, then drain it to underflow.
    task automatic test_stack_bounds();
        logic [15:0] d;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            logic [2:0] o;
            o = (i < 10) ? 3'd4 : 3'd5;
            d = 16'($urandom);
            model(o, 16'h0, d, 16'h0, 3'(i), i % 2);
            issue(o, 16'h0, d, 16'h0, 3'(i), i % 2);
            vectors++; if (obs_err !== exp_err || obs_sp !== exp_sp || obs_req_cycles !== exp_req_cycles) begin
                miscompares++; $display("FAIL bounds_%0d got=err%b sp%h req%0d exp=err%b sp%h req%0d",
                                        i, obs_err, obs_sp, obs_req_cycles, exp_err, exp_sp, exp_req_cycles); end
            vectors++; if (obs_wb_valid !== exp_wb_valid || obs_wb_data !== exp_wb_data) begin
                miscompares++; $display("FAIL bounds_wb_%0d got=%b/%h exp=%b/%h",
                                        i, obs_wb_valid, obs_wb_data, exp_wb_valid, exp_wb_data); end
        end
    endtask

    // Random ops issued back to back at the maximum accept rate.
    task automatic test_back_to_back();
        logic [2:0] o, idx;
        logic [15:0] rs, rd, im;
        int lat;
        for (int n = 0; n < 150; n++) begin
            o = 3'($urandom_range(0, 7));
            rs = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 63));
            rd = 16'($urandom); im = 16'($urandom_range(0, 15)); idx = 3'($urandom);
            lat = $urandom_range(0, 3);
            model(o, rs, rd, im, idx, lat);
            issue(o, rs, rd, im, idx, lat);
            vectors++; if (obs_timeout !== 1'b0) begin miscompares++; $display("FAIL b2b_timeout_%0d got=1 exp=0", n); end
            vectors++; if (obs_req_cycles !== exp_req_cycles || obs_unstable !== 1'b0) begin
                miscompares++; $display("FAIL b2b_req_%0d got=%0d/%b exp=%0d/0", n, obs_req_cycles, obs_unstable, exp_req_cycles); end
            if (exp_access) begin
                vectors++; if (obs_addr !== exp_addr || obs_we !== exp_we || obs_wdata !== exp_wdata) begin
                    miscompares++; $display("FAIL b2b_bus_%0d got=%h/%b/%h exp=%h/%b/%h",
                                            n, obs_addr, obs_we, obs_wdata, exp_addr, exp_we, exp_wdata); end
            end
            vectors++; if (obs_done_cycle !== exp_done_cycle || obs_busy_ready !== 1'b0 || obs_ready_after !== 1'b1) begin
                miscompares++; $display("FAIL b2b_timing_%0d got=%0d/%b/%b exp=%0d/0/1",
                                        n, obs_done_cycle, obs_busy_ready, obs_ready_after, exp_done_cycle); end
            vectors++; if (obs_wb_valid !== exp_wb_valid || obs_wb_idx !== exp_wb_idx || obs_wb_data !== exp_wb_data) begin
                miscompares++; $display("FAIL b2b_wb_%0d got=%b/%0d/%h exp=%b/%0d/%h", n, obs_wb_valid,
                                        obs_wb_idx, obs_wb_data, exp_wb_valid, exp_wb_idx, exp_wb_data); end
            vectors++; if (obs_err !== exp_err || obs_sp !== exp_sp) begin
                miscompares++; $display("FAIL b2b_sp_%0d got=%b/%h exp=%b/%h", n, obs_err, obs_sp, exp_err, exp_sp); end
        end
    endtask

    task automatic test_reset_mid_access();
        apply_reset();
        in_valid = 1; op = 3'd4; rd_val = 16'h5555; rs_val = 16'h0; imm = 16'h0; rd_idx = 3'd0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        vectors++; if (mem_bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL rst_mid_req_before got=%b exp=1", mem_bus.mem_req); end
        #2 rst_n = 0;
        #1;
        vectors++; if (mem_bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_mid_req_drop got=%b exp=0", mem_bus.mem_req); end
        @(negedge clk);
        rst_n = 1;
        sp_model = SP_INIT;
        @(negedge clk);
        vectors++; if (sp_o !== SP_INIT || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL rst_mid_after got=%h/%b exp=%h/1", sp_o, in_ready, SP_INIT); end
        vectors++; if (done !== 1'b0 || mem_bus.mem_req !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid_quiet got=%b/%b exp=0/0", done, mem_bus.mem_req); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_valid = 0; op = 0; rs_val = 0; rd_val = 0; imm = 0; rd_idx = 0;
        mem_bus.mem_ready = 0; mem_bus.mem_rdata = 0;
        sp_model = SP_INIT;
        apply_reset();
        test_reset();
        test_ldm();
        test_std_wait();
        test_push_pop();
        test_pop_underflow();
        test_ldd_wrap();
        test_stack_bounds();
        test_back_to_back();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
